mem_interface_unit: RTL and testbench

- Multicycle memory access sequencer between `control_unit` and the external memory bus.
- Captures the single-cycle `MemRead`/`MemWrite` strobes from the control FSM and selects the PC or ALU address via `IorD`.
- Runs a req/ack handshake with memory, then latches read data into the memory data register (`MemData`).
- Raises `MemBusy` so the control unit's state register can be frozen until the access completes.

---
 rtl/cpu16_pkg.sv | 17 +
 rtl/mem_timeout_counter.sv | 27 ++
 rtl/mem_interface_unit.sv | 103 ++++++++++
 tb/tb_mem_interface_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu16_pkg.sv
// Shared cpu16 types: memory sequencer state encoding, bus widths, IorD codes.
package cpu16_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic IORD_PC  = 1'b1;
  localparam logic IORD_ALU = 1'b0;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_REQ  = 2'd1,
    MS_DONE = 2'd2,
    MS_ERR  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating REQ wait counter; expired flags count == LIMIT.
// LIMIT must be at least 1.
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (en && count != MAX)
      count <= count + 1'b1;
  end

  assign expired = (count == MAX);

endmodule

// File: rtl/mem_interface_unit.sv
// Multicycle memory access sequencer (req/ack) with MDR.
// Optional REQ timeout enabled by defining MEM_TIMEOUT_EN.
module mem_interface_unit
  import cpu16_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] MemData,
  output logic              MemDone,
  output logic              MemBusy,
  output logic              BusError,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  mem_state_t state, state_n;
  logic start;
  logic timeout;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    sel_addr = ALUOut;
    unique case (IorD)
      IORD_PC:  sel_addr = PC;
      IORD_ALU: sel_addr = ALUOut;
      default:  sel_addr = ALUOut;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  mem_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLK),
    .rst    (Reset),
    .clr    (state != MS_REQ),
    .en     ((state == MS_REQ) && !bus_ack),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  assign start = (state == MS_IDLE || state == MS_DONE)
               && (MemRead || MemWrite);

  always_comb begin
    state_n = state;
    unique case (state)
      MS_IDLE, MS_DONE:
        state_n = start ? MS_REQ : MS_IDLE;
      MS_REQ:
        if (bus_ack)
          state_n = MS_DONE;
        else if (timeout)
          state_n = MS_ERR;
      default:
        state_n = MS_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= MS_IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      MemData   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        bus_addr  <= sel_addr;
        bus_wdata <= WriteData;
        bus_we    <= MemWrite;
      end
      // reads only; a completed write leaves the MDR alone
      if (state == MS_REQ && bus_ack && !bus_we)
        MemData <= bus_rdata;
    end
  end

  assign bus_req  = (state == MS_REQ);
  assign MemBusy  = (state == MS_REQ);
  assign MemDone  = (state == MS_DONE) || (state == MS_ERR);
  assign BusError = (state == MS_ERR);

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit.
// Covers fetch, waited store, both strobes, back-to-back, timeout, reset.
module tb_mem_interface_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        MemRead, MemWrite, IorD;
  logic [15:0] PC, ALUOut, WriteData;
  logic [15:0] MemData;
  logic        MemDone, MemBusy, BusError;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  mem_interface_unit dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IorD     (IorD),
    .PC       (PC),
    .ALUOut   (ALUOut),
    .WriteData(WriteData),
    .MemData  (MemData),
    .MemDone  (MemDone),
    .MemBusy  (MemBusy),
    .BusError (BusError),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic [15:0] mdr);
    chk({tag, "_req"}, {15'd0, bus_req}, 16'd0);
    chk({tag, "_busy"}, {15'd0, MemBusy}, 16'd0);
    chk({tag, "_done"}, {15'd0, MemDone}, 16'd0);
    chk({tag, "_err"}, {15'd0, BusError}, 16'd0);
    chk({tag, "_mdr"}, MemData, mdr);
  endtask

  initial begin
    Reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    PC = 16'h0;
    ALUOut = 16'h0;
    WriteData = 16'h0;
    bus_rdata = 16'h0;
    bus_ack = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();

    chk_idle("rst", 16'h0000);
    chk("rst_we", {15'd0, bus_we}, 16'd0);
    chk("rst_addr", bus_addr, 16'h0000);
    chk("rst_wdata", bus_wdata, 16'h0000);

    // fetch, zero wait
    MemRead = 1'b1; IorD = 1'b1; PC = 16'h0040; ALUOut = 16'h9999;
    tick();
    MemRead = 1'b0;
    chk("f_req", {15'd0, bus_req}, 16'd1);
    chk("f_busy", {15'd0, MemBusy}, 16'd1);
    chk("f_addr", bus_addr, 16'h0040);
    chk("f_we", {15'd0, bus_we}, 16'd0);
    chk("f_done0", {15'd0, MemDone}, 16'd0);
    bus_ack = 1'b1; bus_rdata = 16'hA5C3;
    tick();
    bus_ack = 1'b0; bus_rdata = 16'h0;
    chk("f_done", {15'd0, MemDone}, 16'd1);
    chk("f_mdr", MemData, 16'hA5C3);
    chk("f_req_off", {15'd0, bus_req}, 16'd0);
    chk("f_busy_off", {15'd0, MemBusy}, 16'd0);
    tick();
    chk_idle("f_idle", 16'hA5C3);

    // store, 3 wait cycles; inputs change and a stray strobe arrives in REQ
    MemWrite = 1'b1; IorD = 1'b0; ALUOut = 16'h1234; WriteData = 16'hBEEF;
    tick();
    MemWrite = 1'b0; ALUOut = 16'h0; WriteData = 16'h0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s_req%0d", i), {15'd0, bus_req}, 16'd1);
      chk($sformatf("s_addr%0d", i), bus_addr, 16'h1234);
      chk($sformatf("s_wdata%0d", i), bus_wdata, 16'hBEEF);
      chk($sformatf("s_we%0d", i), {15'd0, bus_we}, 16'd1);
      MemRead = (i == 1);
      IorD = 1'b1; PC = 16'h7777;
      if (i == 3) begin
        bus_ack = 1'b1; bus_rdata = 16'hDEAD;
      end
      tick();
    end
    MemRead = 1'b0; bus_ack = 1'b0;
    chk("s_done", {15'd0, MemDone}, 16'd1);
    chk("s_mdr", MemData, 16'hA5C3);

    // both strobes in DONE cycle: write wins, back-to-back
    MemRead = 1'b1; MemWrite = 1'b1; IorD = 1'b1;
    PC = 16'h0100; WriteData = 16'h5555;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("b_req", {15'd0, bus_req}, 16'd1);
    chk("b_we", {15'd0, bus_we}, 16'd1);
    chk("b_addr", bus_addr, 16'h0100);
    chk("b_wdata", bus_wdata, 16'h5555);
    bus_ack = 1'b1; bus_rdata = 16'hFFFF;
    tick();
    bus_ack = 1'b0;
    chk("b_done", {15'd0, MemDone}, 16'd1);
    chk("b_mdr", MemData, 16'hA5C3);

    // read issued from DONE, no idle gap
    MemRead = 1'b1; IorD = 1'b0; ALUOut = 16'h0200;
    tick();
    MemRead = 1'b0;
    chk("r_req", {15'd0, bus_req}, 16'd1);
    chk("r_we", {15'd0, bus_we}, 16'd0);
    chk("r_addr", bus_addr, 16'h0200);
    bus_ack = 1'b1; bus_rdata = 16'h0F0F;
    tick();
    bus_ack = 1'b0;
    chk("r_done", {15'd0, MemDone}, 16'd1);
    chk("r_mdr", MemData, 16'h0F0F);
    tick();

    // ack outside REQ is ignored
    bus_ack = 1'b1; bus_rdata = 16'h1111;
    tick();
    bus_ack = 1'b0;
    chk_idle("stray", 16'h0F0F);

    // no ack: timeout build errors out, default build keeps waiting
    MemRead = 1'b1; IorD = 1'b1; PC = 16'h0300;
    tick();
    MemRead = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t_req%0d", i), {15'd0, bus_req}, 16'd1);
      tick();
    end
    chk("t_err", {15'd0, BusError}, 16'd1);
    chk("t_done", {15'd0, MemDone}, 16'd1);
    chk("t_req_off", {15'd0, bus_req}, 16'd0);
    chk("t_mdr", MemData, 16'h0F0F);
    tick();
    chk_idle("t_idle", 16'h0F0F);
`else
    for (int i = 0; i < 20; i++)
      tick();
    chk("w_req", {15'd0, bus_req}, 16'd1);
    chk("w_err", {15'd0, BusError}, 16'd0);
    chk("w_done", {15'd0, MemDone}, 16'd0);
    bus_ack = 1'b1; bus_rdata = 16'h2468;
    tick();
    bus_ack = 1'b0;
    chk("w_mdr", MemData, 16'h2468);
    chk("w_fin", {15'd0, MemDone}, 16'd1);
    tick();
`endif

    // reset mid-REQ, then late ack
    MemRead = 1'b1; IorD = 1'b0; ALUOut = 16'h0ABC;
    tick();
    MemRead = 1'b0;
    chk("m_req", {15'd0, bus_req}, 16'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk_idle("m_rst", 16'h0000);
    chk("m_addr", bus_addr, 16'h0000);
    chk("m_we", {15'd0, bus_we}, 16'd0);
    bus_ack = 1'b1; bus_rdata = 16'h9876;
    tick();
    bus_ack = 1'b0;
    chk_idle("m_late", 16'h0000);
    tick();
    chk("m_after", {15'd0, MemDone}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
